// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, single-outstanding memory reads, and a 2-entry {pc, instruction} FIFO that feeds decode
module instruction_fetch #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      mem_req,
  output logic [BUS_DATA_WIDTH-1:0] mem_addr,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [BUS_DATA_WIDTH-1:0] mem_rdata,
  output logic [BUS_DATA_WIDTH-1:0] pc,
  output logic [31:0]               outIns,
  output logic                      decode_en
);
  localparam int W = BUS_DATA_WIDTH;
  typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;
  state_t state, nextState;
  logic [W-1:0] fetchPc;
  logic [W-1:0] pcMem [2];
  logic [31:0] insMem [2];
  logic wrPtr, rdPtr;
  logic [1:0] count;
  logic empty, push, granted;
  logic [31:0] fetchedIns;
  // State register; a redirect during reset-free operation is handled by nextState
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= REQ;
    else state <= nextState;
  // Next state: a redirect turns any in-flight or just-granted read into a drained one
  always_comb begin
    nextState = state == REQ ? (granted ? (redirect ? DRAIN : WAIT) : REQ) :
                mem_rvalid ? REQ :
                (state == WAIT && !redirect) ? WAIT : DRAIN;
  end
  // Outputs: in REQ nothing is outstanding, so the issue rule reduces to a non-full FIFO
  always_comb begin
    empty      = count == 2'd0;
    mem_req    = reset_n && state == REQ && count < 2'd2;
    mem_addr   = fetchPc & ~W'(7);
    granted    = mem_req && mem_gnt;
    fetchedIns = fetchPc[2] ? mem_rdata[32 +: 32] : mem_rdata[0 +: 32];
    push       = state == WAIT && mem_rvalid && !redirect;
    decode_en  = !empty && !stall && !redirect;
    pc         = empty ? '0 : pcMem[rdPtr];
    outIns     = empty ? '0 : insMem[rdPtr];
  end
  // Fetch PC: redirect wins over the sequential advance on a delivered beat
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fetchPc <= RESET_PC;
    else if (redirect) fetchPc <= redirect_pc & ~W'(3);
    else if (push) fetchPc <= fetchPc + W'(4);
  // FIFO bookkeeping: redirect flushes, push and pop together leave count unchanged
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else if (redirect) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      wrPtr <= wrPtr ^ push;
      rdPtr <= rdPtr ^ decode_en;
      count <= count + {1'b0, push} - {1'b0, decode_en};
    end
  // FIFO storage; contents are masked by the empty check so no reset is needed
  always_ff @(posedge clk)
    if (push) begin
      pcMem[wrPtr]  <= fetchPc;
      insMem[wrPtr] <= fetchedIns;
    end
  noPushWhenFull: assert property (@(posedge clk) disable iff (!reset_n) !(push && count == 2'd2));
  noRvalidInReq: assert property (@(posedge clk) disable iff (!reset_n) !(state == REQ && mem_rvalid));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table plus hand-written reset and slow-grant sequences
module tb_instruction_fetch;
  localparam logic [63:0] D  = 64'h00A00093_00500113;
  localparam logic [63:0] D2 = 64'h11111111_22222222;
  localparam logic [63:0] D3 = 64'hCAFEF00D_0BADBEEF;
  localparam logic [63:0] D4 = 64'h44444444_55555555;
  localparam logic [63:0] D5 = 64'h66666666_77777777;
  logic clk = 0, reset_n = 0, stall = 0, redirect = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [63:0] redirect_pc = '0, mem_rdata = '0;
  logic mem_req, decode_en;
  logic [63:0] mem_addr, pc;
  logic [31:0] outIns;
  int nCompared = 0, nMismatch = 0;
  typedef struct {
    logic stall, redir; logic [63:0] rpc; logic gnt, rv; logic [63:0] rdata;
    logic eReq; logic [63:0] eAddr; logic eDec; logic [63:0] ePc; logic [31:0] eIns;
  } vec_t;
  vec_t vecs[36];
  instruction_fetch #(.BUS_DATA_WIDTH(64), .RESET_PC(64'h1000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .pc(pc), .outIns(outIns), .decode_en(decode_en)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask
  task automatic checkOut(input int idx, input logic eReq, input logic [63:0] eAddr, input logic eDec,
                          input logic [63:0] ePc, input logic [31:0] eIns);
    check("mem_req", idx, 64'(mem_req), 64'(eReq));
    check("mem_addr", idx, mem_addr, eAddr);
    check("decode_en", idx, 64'(decode_en), 64'(eDec));
    check("pc", idx, pc, ePc);
    check("outIns", idx, 64'(outIns), 64'(eIns));
  endtask
  task automatic cyc(input int idx, input vec_t v);
    stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rdata;
    #1 checkOut(idx, v.eReq, v.eAddr, v.eDec, v.ePc, v.eIns);
    @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{0,0,0,1,0,0,  1,64'h1000,0,0,0};
    vecs[1]  = '{0,0,0,0,1,D,  0,64'h1000,0,0,0};
    vecs[2]  = '{0,0,0,1,0,0,  1,64'h1000,1,64'h1000,32'h00500113};
    vecs[3]  = '{0,0,0,0,1,D,  0,64'h1000,0,0,0};
    vecs[4]  = '{1,0,0,1,0,0,  1,64'h1008,0,64'h1004,32'h00A00093};
    vecs[5]  = '{1,0,0,0,1,D2, 0,64'h1008,0,64'h1004,32'h00A00093};
    for (int i = 6; i < 14; i++) vecs[i] = '{1,0,0,0,0,0, 0,64'h1008,0,64'h1004,32'h00A00093};
    vecs[14] = '{0,0,0,0,0,0,  0,64'h1008,1,64'h1004,32'h00A00093};
    vecs[15] = '{0,0,0,0,0,0,  1,64'h1008,1,64'h1008,32'h22222222};
    vecs[16] = '{0,0,0,1,0,0,  1,64'h1008,0,0,0};
    vecs[17] = '{0,1,64'h2006,0,0,0, 0,64'h1008,0,0,0};
    vecs[18] = '{0,0,0,0,1,D,  0,64'h2000,0,0,0};
    vecs[19] = '{0,0,0,1,0,0,  1,64'h2000,0,0,0};
    vecs[20] = '{0,0,0,0,1,D3, 0,64'h2000,0,0,0};
    vecs[21] = '{0,0,0,0,0,0,  1,64'h2008,1,64'h2004,32'hCAFEF00D};
    vecs[22] = '{0,0,0,1,0,0,  1,64'h2008,0,0,0};
    vecs[23] = '{0,0,0,0,1,D4, 0,64'h2008,0,0,0};
    vecs[24] = '{1,1,64'h3000,1,0,0, 1,64'h2008,0,64'h2008,32'h55555555};
    vecs[25] = '{0,0,0,0,0,0,  0,64'h3000,0,0,0};
    vecs[26] = '{0,0,0,0,1,D4, 0,64'h3000,0,0,0};
    vecs[27] = '{0,0,0,1,0,0,  1,64'h3000,0,0,0};
    vecs[28] = '{0,0,0,0,1,D5, 0,64'h3000,0,0,0};
    vecs[29] = '{0,0,0,0,0,0,  1,64'h3000,1,64'h3000,32'h77777777};
    vecs[30] = '{0,1,64'h400B,0,0,0, 1,64'h3000,0,0,0};
    vecs[31] = '{0,0,0,1,0,0,  1,64'h4008,0,0,0};
    vecs[32] = '{0,1,64'h5004,0,1,D, 0,64'h4008,0,0,0};
    vecs[33] = '{0,0,0,1,0,0,  1,64'h5000,0,0,0};
    vecs[34] = '{0,0,0,0,1,D,  0,64'h5000,0,0,0};
    vecs[35] = '{0,0,0,0,0,0,  1,64'h5008,1,64'h5004,32'h00A00093};
    repeat (2) @(negedge clk);
    checkOut(-1, 0, 64'h1000, 0, 0, 0);
    reset_n = 1;
    for (int i = 0; i < 36; i++) cyc(i, vecs[i]);
    cyc(100, '{0,0,0,1,0,0, 1,64'h5008,0,0,0});
    cyc(101, '{0,0,0,0,1,D, 0,64'h5008,0,0,0});
    cyc(102, '{1,0,0,1,0,0, 1,64'h5008,0,64'h5008,32'h00500113});
    stall = 0; mem_gnt = 0;
    #1 checkOut(103, 0, 64'h5008, 1, 64'h5008, 32'h00500113);
    #1 reset_n = 0;
    #1 checkOut(104, 0, 64'h1000, 0, 0, 0);
    mem_rvalid = 1; mem_rdata = D3;
    @(negedge clk);
    mem_rvalid = 0; reset_n = 1;
    #1 checkOut(105, 1, 64'h1000, 0, 0, 0);
    #1 reset_n = 0;
    #1 checkOut(106, 0, 64'h1000, 0, 0, 0);
    #1 reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(200 + i, '{0,0,0,0,0,0, 1,64'h1000,0,0,0});
    cyc(203, '{0,0,0,1,0,0, 1,64'h1000,0,0,0});
    cyc(204, '{0,0,0,0,1,D, 0,64'h1000,0,0,0});
    cyc(205, '{0,0,0,0,0,0, 1,64'h1000,1,64'h1000,32'h00500113});
    cyc(206, '{0,0,0,0,0,0, 1,64'h1000,0,0,0});
    cyc(207, '{0,0,0,1,0,0, 1,64'h1000,0,0,0});
    cyc(208, '{0,0,0,0,1,D, 0,64'h1000,0,0,0});
    cyc(209, '{0,0,0,0,0,0, 1,64'h1008,1,64'h1004,32'h00A00093});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
